// File: rtl/iris_layer_ctrl.sv
// Output-layer sequencer for the Iris network: launches the neurons,
// collects their outputs on Ready and reports the signed argmax class.
module iris_layer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_OUT    = 3,
  parameter int IDX_WIDTH  = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start,
  input  logic [NUM_OUT-1:0]            Ready,
  input  logic [NUM_OUT*DATA_WIDTH-1:0] Y_in,
  output logic                          Run,
  output logic                          En,
  output logic                          Nrst,
  output logic                          Busy,
  output logic [IDX_WIDTH-1:0]          Class,
  output logic [DATA_WIDTH-1:0]         Max_val,
  output logic                          Valid,
  output logic                          Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ARGMAX,
    S_ERR
  } state_t;

  state_t state, state_n;

  logic [NUM_OUT-1:0]           rdy_seen;
  logic [NUM_OUT-1:0]           rdy_all;
  logic                         done;
  logic                         expired;
  logic signed [DATA_WIDTH-1:0] cap [NUM_OUT];
  logic [7:0]                   wd_cnt;
  logic [IDX_WIDTH-1:0]         k;
  logic                         k_last;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic [IDX_WIDTH-1:0]         best_idx_n;
  logic signed [DATA_WIDTH-1:0] best;
  logic signed [DATA_WIDTH-1:0] best_n;
  logic signed [DATA_WIDTH-1:0] cand;
  logic                         take;

  assign rdy_all = rdy_seen | Ready;
  assign done    = &rdy_all;
  assign expired = (wd_cnt == 8'(TIMEOUT - 1));
  assign k_last  = (k == IDX_WIDTH'(NUM_OUT - 1));
  assign Busy    = (state != S_IDLE);

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (k == IDX_WIDTH'(i)) cand = cap[i];
    end
  end

  // strict compare keeps the lowest index on ties
  assign take       = (k == '0) || (cand > best);
  assign best_n     = take ? cand : best;
  assign best_idx_n = take ? k : best_idx;

  always_comb begin
    state_n = state;
    Run     = 1'b0;
    En      = 1'b0;
    Nrst    = 1'b0;
    Error   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) state_n = S_LAUNCH;
      end
      S_LAUNCH: begin
        Run     = 1'b1;
        En      = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        En = 1'b1;
        if (done)         state_n = S_ARGMAX;
        else if (expired) state_n = S_ERR;
      end
      S_ARGMAX: begin
        if (k_last) state_n = S_IDLE;
      end
      S_ERR: begin
        Nrst    = 1'b1;
        Error   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rdy_seen <= '0;
      wd_cnt   <= '0;
      k        <= '0;
      best     <= '0;
      best_idx <= '0;
      Class    <= '0;
      Max_val  <= '0;
      Valid    <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) cap[i] <= '0;
    end else begin
      state <= state_n;
      Valid <= 1'b0;
      unique case (state)
        S_LAUNCH: begin
          rdy_seen <= '0;
          wd_cnt   <= '0;
          k        <= '0;
          for (int i = 0; i < NUM_OUT; i++) cap[i] <= '0;
        end
        S_WAIT: begin
          rdy_seen <= rdy_all;
          wd_cnt   <= wd_cnt + 8'd1;
          for (int i = 0; i < NUM_OUT; i++) begin
            if (Ready[i]) cap[i] <= Y_in[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        S_ARGMAX: begin
          best     <= best_n;
          best_idx <= best_idx_n;
          k        <= k + IDX_WIDTH'(1);
          if (k_last) begin
            Class   <= best_idx_n;
            Max_val <= best_n;
            Valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iris_layer_ctrl.sv
// Bench for iris_layer_ctrl: directed and random inference passes
// checked cycle by cycle against a schedule-level reference model.
module tb_iris_layer_ctrl;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int IW = 2;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [N-1:0]  Ready;
  logic [N*DW-1:0] Y_in;
  logic          Run, En, Nrst, Busy, Valid, Error;
  logic [IW-1:0] Class;
  logic [DW-1:0] Max_val;

  int errors = 0;
  int checks = 0;

  int                 off [N][2];
  logic signed [DW-1:0] val [N][2];
  logic [IW-1:0]      exp_class = '0;
  logic [DW-1:0]      exp_max = '0;

  iris_layer_ctrl #(
    .DATA_WIDTH(DW), .NUM_OUT(N), .IDX_WIDTH(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .Start(Start), .Ready(Ready), .Y_in(Y_in),
    .Run(Run), .En(En), .Nrst(Nrst), .Busy(Busy), .Class(Class),
    .Max_val(Max_val), .Valid(Valid), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int rel,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s rel=%0d got=%0h exp=%0h", tag, rel, got, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 2; p++) begin
        off[i][p] = -1;
        val[i][p] = '0;
      end
  endtask

  task automatic sched3(input int o, input int v0, input int v1, input int v2);
    clear_sched();
    for (int i = 0; i < N; i++) off[i][0] = o;
    val[0][0] = DW'(v0);
    val[1][0] = DW'(v1);
    val[2][0] = DW'(v2);
  endtask

  // Called while the DUT is idle, #1 after an edge; returns #1 after
  // the edge that opens the first idle cycle of the pass.
  task automatic run_pass(input bit hold, input string tag);
    int  f, w, wl, endc, errc, bo, best, bidx;
    int  c [N];
    bit  ok;
    w = 2; ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      f = 1000;
      for (int p = 0; p < 2; p++)
        if (off[i][p] >= 2 && off[i][p] < f) f = off[i][p];
      if (f == 1000) ok = 1'b0;
      else if (f > w) w = f;
    end
    best = 0; bidx = 0;
    if (ok && w <= 1 + TO) begin
      endc = w + N + 1; errc = -1; wl = w;
      for (int i = 0; i < N; i++) begin
        bo = -1; c[i] = 0;
        for (int p = 0; p < 2; p++)
          if (off[i][p] >= 2 && off[i][p] <= w && off[i][p] >= bo) begin
            bo = off[i][p];
            c[i] = $signed(val[i][p]);
          end
      end
      for (int i = 0; i < N; i++)
        if (i == 0 || c[i] > best) begin
          best = c[i];
          bidx = i;
        end
    end else begin
      ok = 1'b0; errc = 2 + TO; endc = 3 + TO; wl = 1 + TO;
    end
    Start = 1'b1;
    Ready = '0;
    Y_in  = (N*DW)'($urandom);
    @(posedge clk); #1;
    for (int rel = 1; rel <= endc; rel++) begin
      Start = hold && (rel < endc);
      if (ok && rel == endc) begin
        exp_class = IW'(bidx);
        exp_max   = DW'(best);
      end
      check({tag, ".run"},   rel, 32'(Run),   32'(rel == 1));
      check({tag, ".en"},    rel, 32'(En),    32'(rel <= wl));
      check({tag, ".busy"},  rel, 32'(Busy),  32'(rel < endc));
      check({tag, ".valid"}, rel, 32'(Valid), 32'(ok && rel == endc));
      check({tag, ".error"}, rel, 32'(Error), 32'(rel == errc));
      check({tag, ".nrst"},  rel, 32'(Nrst),  32'(rel == errc));
      check({tag, ".class"}, rel, 32'(Class), 32'(exp_class));
      check({tag, ".max"},   rel, 32'(Max_val), 32'(exp_max));
      Ready = '0;
      Y_in  = (N*DW)'($urandom);
      for (int i = 0; i < N; i++)
        for (int p = 0; p < 2; p++)
          if (off[i][p] == rel) begin
            Ready[i] = 1'b1;
            Y_in[i*DW +: DW] = val[i][p];
          end
      if (rel < endc) begin
        @(posedge clk); #1;
      end
    end
    Ready = '0;
  endtask

  task automatic idle(input int n, input string tag);
    Start = 1'b0;
    Ready = '0;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      check({tag, ".busy"},  j, 32'(Busy),  32'd0);
      check({tag, ".run"},   j, 32'(Run),   32'd0);
      check({tag, ".valid"}, j, 32'(Valid), 32'd0);
      check({tag, ".class"}, j, 32'(Class), 32'(exp_class));
    end
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Ready = '0; Y_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.run",   0, 32'(Run),   32'd0);
    check("rst.en",    0, 32'(En),    32'd0);
    check("rst.nrst",  0, 32'(Nrst),  32'd0);
    check("rst.busy",  0, 32'(Busy),  32'd0);
    check("rst.valid", 0, 32'(Valid), 32'd0);
    check("rst.error", 0, 32'(Error), 32'd0);
    check("rst.class", 0, 32'(Class), 32'd0);
    check("rst.max",   0, 32'(Max_val), 32'd0);
    rst = 1'b0;
    idle(2, "idle0");

    sched3(8, 5, 20, -3);   run_pass(0, "basic");
    idle(1, "idle1");
    sched3(8, 12, 12, 4);   run_pass(0, "tie");
    sched3(8, 0, 0, 0);     run_pass(0, "zero");
    sched3(8, -8, -2, -5);  run_pass(0, "neg");
    idle(1, "idle2");

    clear_sched();
    off[0][0] = 3; val[0][0] = 8'sd7;
    off[1][0] = 6; val[1][0] = 8'sd3;
    off[2][0] = 9; val[2][0] = 8'sd9;
    run_pass(0, "stagger");

    clear_sched();
    off[0][0] = 8; val[0][0] = 8'sd40;
    off[1][0] = 8; val[1][0] = 8'sd41;
    run_pass(0, "timeout");
    sched3(5, 1, 2, 3);     run_pass(1, "after_to");

    clear_sched();
    off[0][0] = 4; val[0][0] = 8'sd50;
    off[0][1] = 7; val[0][1] = -8'sd60;
    off[1][0] = 5; val[1][0] = -8'sd10;
    off[2][0] = 5; val[2][0] = -8'sd20;
    run_pass(1, "recap");

    clear_sched();
    off[0][0] = 6; val[0][0] = 8'sd1;
    off[1][0] = 1; val[1][0] = 8'sd99;
    off[2][0] = 6; val[2][0] = 8'sd2;
    run_pass(0, "launch_rdy");

    sched3(3, 4, 4, 4);
    off[2][0] = 1 + TO; val[2][0] = 8'sd100;
    run_pass(0, "edge_ok");
    sched3(3, 4, 4, 4);
    off[2][0] = 2 + TO; val[2][0] = 8'sd101;
    run_pass(0, "edge_to");

    for (int t = 0; t < 5; t++) begin
      sched3($urandom_range(2, 9), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255));
      run_pass(1, "b2b");
    end
    idle(2, "idle3");

    for (int t = 0; t < 25; t++) begin
      clear_sched();
      for (int i = 0; i < N; i++) begin
        off[i][0] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 12));
        val[i][0] = DW'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          off[i][1] = $urandom_range(2, 14);
          val[i][1] = DW'($urandom);
        end
      end
      run_pass(t[0], "rand");
      if (t % 4 == 0) idle(1, "idle_r");
    end

    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid.busy", 4, 32'(Busy), 32'd1);
    check("mid.en",   4, 32'(En),   32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_class = '0;
    exp_max   = '0;
    check("mrst.busy",  0, 32'(Busy),  32'd0);
    check("mrst.en",    0, 32'(En),    32'd0);
    check("mrst.run",   0, 32'(Run),   32'd0);
    check("mrst.nrst",  0, 32'(Nrst),  32'd0);
    check("mrst.error", 0, 32'(Error), 32'd0);
    check("mrst.valid", 0, 32'(Valid), 32'd0);
    check("mrst.class", 0, 32'(Class), 32'd0);
    check("mrst.max",   0, 32'(Max_val), 32'd0);
    Ready = '1;
    Y_in  = 24'h7f7f7f;
    @(posedge clk); #1;
    Ready = '0;
    idle(8, "late");

    sched3(8, 5, 20, -3);
    run_pass(0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
